// File: rtl/input_stage_fifo.sv
// input_stage_fifo: first-word-fall-through sample queue that decouples
// the external producer from the counter/compare datapath input.
module input_stage_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             push;
   logic             pop;

   assign full      = (cnt == CW'(DEPTH));
   assign empty     = (cnt == '0);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign count     = cnt;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Stale entries stay hidden behind the empty mask
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_input_stage_fifo.sv
// tb_input_stage_fifo: directed plus randomized stimulus, checked every
// cycle against a queue-based model of the buffering stage.
module tb_input_stage_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [2:0]       count;
   logic             full;
   logic             empty;

   input_stage_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Reference model: an unbounded queue limited to DEPTH by the rules
   logic [WIDTH-1:0] mq[$];
   bit               started = 0;
   bit               m_push;
   bit               m_pop;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
      end else begin
         m_push = in_valid && (mq.size() < DEPTH);
         m_pop  = out_ready && (mq.size() > 0);
         if (m_pop) void'(mq.pop_front());
         if (m_push) mq.push_back(in_data);
      end
      started = 1;
   end

   always @(negedge clk) begin
      if (started) begin
         check("count", 32'(count), 32'(mq.size()));
         check("full", 32'(full), 32'(mq.size() == DEPTH));
         check("empty", 32'(empty), 32'(mq.size() == 0));
         check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
         check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
         check("out_data", 32'(out_data),
               (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      cyc();
      in_valid = 1'b0;
   endtask

   // Pop everything with out_ready high, collecting delivered samples
   task automatic drain(output logic [7:0] got[$]);
      got = {};
      out_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (out_valid) got.push_back(out_data);
         if (in_valid && in_ready) begin
            cyc();
            in_valid = 1'b0;
         end else if (!out_valid && !in_valid) begin
            break;
         end else begin
            cyc();
         end
      end
      out_ready = 1'b0;
   endtask

   logic [7:0] got[$];

   initial begin
      rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
      cyc();
      cyc();
      rst = 1'b0; in_valid = 1'b0;
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'h00);

      // Fall-through with consumer stalled
      push_one(8'h11);
      check("ft_valid", 32'(out_valid), 32'd1);
      check("ft_data", 32'(out_data), 32'h11);
      check("ft_count", 32'(count), 32'd1);
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("ft_hold", 32'(out_data), 32'h11);
      end
      drain(got);
      check("ft_drain_n", 32'(got.size()), 32'd1);
      check("ft_empty", 32'(empty), 32'd1);

      // Fill and back-pressure
      for (int i = 1; i <= 4; i++) push_one(8'(i));
      check("fill_full", 32'(full), 32'd1);
      check("fill_in_ready", 32'(in_ready), 32'd0);
      check("fill_count", 32'(count), 32'd4);
      in_valid = 1'b1; in_data = 8'h05;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("bp_count", 32'(count), 32'd4);
      end
      drain(got);
      check("bp_n", 32'(got.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < got.size()) check("bp_order", 32'(got[i]), 32'(i + 1));
      end
      check("bp_empty", 32'(empty), 32'd1);

      // Full with simultaneous pop: no same-cycle slot
      for (int i = 1; i <= 4; i++) push_one(8'h40 + 8'(i));
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h45;
      check("fp_in_ready0", 32'(in_ready), 32'd0);
      cyc();
      check("fp_count", 32'(count), 32'd3);
      check("fp_in_ready1", 32'(in_ready), 32'd1);
      out_ready = 1'b0;
      cyc();
      in_valid = 1'b0;
      check("fp_accept", 32'(count), 32'd4);
      drain(got);
      check("fp_n", 32'(got.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < got.size()) check("fp_order", 32'(got[i]), 32'h42 + i);
      end

      // Wrap-around streaming
      got = {};
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) got.push_back(out_data);
         in_valid = 1'b1; in_data = 8'(i);
         cyc();
         if (count > 1) check("st_count_le1", 32'(count), 32'd1);
      end
      in_valid = 1'b0;
      if (out_valid) got.push_back(out_data);
      cyc();
      out_ready = 1'b0;
      check("st_n", 32'(got.size()), 32'd20);
      for (int i = 0; i < 20; i++) begin
         if (i < got.size()) check("st_order", 32'(got[i]), 32'(i));
      end
      check("st_empty", 32'(empty), 32'd1);

      // Reset mid-operation
      push_one(8'h21); push_one(8'h22); push_one(8'h23);
      check("mr_count", 32'(count), 32'd3);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("mr_empty", 32'(empty), 32'd1);
      check("mr_out_valid", 32'(out_valid), 32'd0);
      push_one(8'h30);
      check("mr_next", 32'(out_data), 32'h30);
      check("mr_next_v", 32'(out_valid), 32'd1);
      drain(got);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 99) < 60);
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 99) < 50);
         rst       = ($urandom_range(0, 199) == 0);
         cyc();
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
